lsu_split: RTL and testbench
============================

Name: lsu_split

Overview:
- Parametrised load/store unit for the MEM stage of the pipelined RV core.
- Replaces the single-cycle combinational store-shift and load-extract logic.
- Adds a valid/ready request handshake toward the pipeline and waits on the data-cache response.
- Generalises to XLEN 32 or 64, and splits misaligned accesses that cross a word boundary into two cache transactions, reassembling load data before sign or zero extension.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64; NB = XLEN/8 bytes per word.
- ADDR_W, 32, address width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV funct3.
  - Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - Stores: 000 sb, 001 sh, 010 sw, 011 sd.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- resp_err  out  1  illegal funct3; valid only with resp_valid.
- dcache_address  out  ADDR_W  word-aligned address; low log2(NB) bits are 0.
- dcache_read  out  1  read strobe.
- dcache_write  out  1  write strobe.
- dcache_wdata  out  XLEN  byte-lane-positioned write data.
- dcache_mbe  out  NB  byte enables.
- dcache_rdata  in  XLEN  read data, valid with dcache_resp.
- dcache_resp  in  1  one-cycle completion of the current cache access.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE immediately.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - dcache_read=0, dcache_write=0, dcache_address=0, dcache_wdata=0, dcache_mbe=0.
  - An in-flight access is abandoned; a later dcache_resp is ignored.
- States: IDLE, ACC0, ACC1, DONE. All outputs are driven from registers.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request.
  - Size: 1/2/4/8 bytes from funct3[1:0].
  - off = addr mod NB.
  - Illegal funct3 → DONE with err=1 and no cache access. Illegal means:
    - loads: 111;
    - loads with XLEN=32: 011 and 110;
    - stores: funct3 ≥ 100;
    - stores with XLEN=32: 011.
  - Legal request → ACC0.
- Split rule:
  - split = (off + size > NB).
  - Form a 2*NB-bit mask = ((1<<size)-1) << off.
  - Form 2*XLEN-bit data = req_wdata << (8*off).
  - ACC0 uses the low halves of mask and data; ACC1 uses the high halves.
- ACC0:
  - dcache_address = addr with low bits cleared.
  - mbe and wdata as above.
  - read or write held high until dcache_resp.
  - On dcache_resp: if a load, capture rdata into low buffer; then go to ACC1 if split, else DONE.
- ACC1:
  - dcache_address = ACC0 address + NB, wrapping modulo 2^ADDR_W.
  - Strobe held until dcache_resp; a load captures into high buffer; then → DONE.
- Strobe timing:
  - Strobes deassert in the cycle after dcache_resp.
  - Between ACC0 and ACC1, strobes are low for exactly one cycle.
- DONE (lasts exactly 1 cycle):
  - resp_valid=1, req_ready=0.
  - Load result:
    - Take the 2*XLEN-bit buffer {high, low} >> (8*off), truncate to size.
    - Sign-extend for lb/lh/lw/ld; zero-extend for lbu/lhu/lwu.
  - Store: resp_rdata=0.
  - Next state is IDLE, so back-to-back requests complete with a minimum 1-cycle IDLE gap.
- Latency:
  - Aligned access with dcache_resp in the first strobe cycle: request accepted at edge N, strobe cycle N+1, resp_valid cycle N+2.
  - Each additional wait cycle or split access adds cycles accordingly.
- dcache_resp in IDLE or DONE is ignored.
- req_valid while req_ready=0 is ignored; the pipeline must hold the request.
- req_funct3 and req_write are sampled only at acceptance.

Test Plan:
- XLEN=32, sw addr 0x1000 data 0xDEADBEEF, resp after 2 wait cycles → single access, address 0x1000, mbe 1111, wdata 0xDEADBEEF. resp_valid exactly one cycle after dcache_resp, resp_err=0.
- XLEN=32, sh addr 0x1003 data 0x0000ABCD → two accesses:
  - ACC0: address 0x1000, mbe 1000, wdata 0xCD000000.
  - One strobe-low gap cycle.
  - ACC1: address 0x1004, mbe 0001, wdata 0x000000AB.
  - Then resp_valid.
- XLEN=32, lb addr 0x2002 with rdata 0x12F45678 → resp_rdata 0xFFFFFFF4. lbu at the same address → 0x000000F4.
- XLEN=32, lw addr 0x2003 with rdata 0xAABBCCDD then 0x11223344 → resp_rdata 0x223344AA. lw addr 0xFFFFFFFE → ACC1 address wraps to 0x00000000.
- XLEN=32, ld (funct3 011) → no strobe asserted, resp_valid with resp_err=1, resp_rdata=0. XLEN=64, lwu addr 0x6 with rdata 0x8877665544332211 then 0x00000000000000AA → resp_rdata 0x0000000000AA8877.
- Reset asserted during ACC0 with dcache_read high → dcache_read=0 immediately, req_ready=1. A dcache_resp arriving afterwards is ignored and produces no resp_valid.

Source files
------------

// File: rtl/lsu_split_if.sv
`timescale 1ns/1ps
// lsu_split_if: request/response and data-cache bus of the MEM-stage load/store unit.
//   req_*    : pipeline request handshake (valid/ready) with op, address, store data
//   resp_*   : one-cycle completion pulse with extended load data and error flag
//   dcache_* : word-aligned cache access with byte enables and completion pulse
// slave  = the load/store unit's view, master = the pipeline/cache side.
interface lsu_split_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   localparam int NB = XLEN / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] dcache_address;
   logic              dcache_read;
   logic              dcache_write;
   logic [XLEN-1:0]   dcache_wdata;
   logic [NB-1:0]     dcache_mbe;
   logic [XLEN-1:0]   dcache_rdata;
   logic              dcache_resp;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  dcache_rdata, dcache_resp,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output dcache_address, dcache_read, dcache_write, dcache_wdata, dcache_mbe
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      output dcache_rdata, dcache_resp,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  dcache_address, dcache_read, dcache_write, dcache_wdata, dcache_mbe
   );
endinterface

// File: rtl/lsu_split.sv
`timescale 1ns/1ps
// lsu_split: MEM-stage load/store unit. Accepts one request at a time, issues one
// or two word-aligned data-cache accesses (two when the access crosses a word
// boundary), reassembles load data and sign/zero extends it.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : lsu_split_if.slave (request, response and data-cache signals)
// All outputs come straight from flops.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first (or only) cache access, strobe held until dcache_resp
// ACC1  | second access of a split; first cycle is the strobe-low gap
// DONE  | one-cycle resp_valid pulse
module lsu_split #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input logic        clk,
   input logic        rst,
   lsu_split_if.slave bus
);
   localparam int NB = XLEN / 8;
   localparam int LB = $clog2(NB);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t              state_q, state_d;
   logic                is_store_q, is_store_d;
   logic [2:0]          f3_q, f3_d;
   logic [LB-1:0]       off_q, off_d;
   logic                split_q, split_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2*NB-1:0]     mask_q, mask_d;
   logic [2*XLEN-1:0]   data_q, data_d;
   logic [XLEN-1:0]     buf_lo_q, buf_lo_d;
   logic [XLEN-1:0]     buf_hi_q, buf_hi_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
   logic                dc_read_q, dc_read_d;
   logic                dc_write_q, dc_write_d;
   logic [ADDR_W-1:0]   dc_addr_q, dc_addr_d;
   logic [XLEN-1:0]     dc_wdata_q, dc_wdata_d;
   logic [NB-1:0]       dc_mbe_q, dc_mbe_d;

   logic [LB-1:0]       req_off;
   logic [2*NB-1:0]     mask_base;
   logic [2*NB-1:0]     req_mask;
   logic [2*XLEN-1:0]   req_data;
   logic [ADDR_W-1:0]   req_word;
   logic                req_illegal;
   logic                finish_load;
   logic [2*XLEN-1:0]   shifted;
   logic [6:0]          nbits;
   logic [XLEN-1:0]     ext;

   always_comb begin
      req_off  = bus.req_addr[LB-1:0];
      req_word = {bus.req_addr[ADDR_W-1:LB], {LB{1'b0}}};
      case (bus.req_funct3[1:0])
         2'd0:    mask_base = (2*NB)'(8'h01);
         2'd1:    mask_base = (2*NB)'(8'h03);
         2'd2:    mask_base = (2*NB)'(8'h0f);
         default: mask_base = (2*NB)'(8'hff);
      endcase
      req_mask = mask_base << req_off;
      req_data = {{XLEN{1'b0}}, bus.req_wdata} << {req_off, 3'b000};
      if (bus.req_write)
         req_illegal = bus.req_funct3[2] || (XLEN == 32 && bus.req_funct3 == 3'b011);
      else
         req_illegal = (bus.req_funct3 == 3'b111) ||
                       (XLEN == 32 && (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110));
   end

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      f3_d         = f3_q;
      off_d        = off_q;
      split_d      = split_q;
      addr_d       = addr_q;
      mask_d       = mask_q;
      data_d       = data_q;
      buf_lo_d     = buf_lo_q;
      buf_hi_d     = buf_hi_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      dc_read_d    = dc_read_q;
      dc_write_d   = dc_write_q;
      dc_addr_d    = dc_addr_q;
      dc_wdata_d   = dc_wdata_q;
      dc_mbe_d     = dc_mbe_q;
      finish_load  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               is_store_d  = bus.req_write;
               f3_d        = bus.req_funct3;
               off_d       = req_off;
               split_d     = |req_mask[2*NB-1:NB];
               addr_d      = req_word;
               mask_d      = req_mask;
               data_d      = req_data;
               buf_lo_d    = '0;
               buf_hi_d    = '0;
               req_ready_d = 1'b0;
               if (req_illegal) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d    = ACC0;
                  dc_addr_d  = req_word;
                  dc_mbe_d   = req_mask[NB-1:0];
                  dc_wdata_d = req_data[XLEN-1:0];
                  dc_read_d  = !bus.req_write;
                  dc_write_d = bus.req_write;
               end
            end
         end
         ACC0: begin
            if (bus.dcache_resp) begin
               dc_read_d  = 1'b0;
               dc_write_d = 1'b0;
               if (!is_store_q) buf_lo_d = bus.dcache_rdata;
               if (split_q) begin
                  // second word staged now; strobe rises after the gap cycle
                  state_d    = ACC1;
                  dc_addr_d  = addr_q + ADDR_W'(NB);
                  dc_mbe_d   = mask_q[2*NB-1:NB];
                  dc_wdata_d = data_q[2*XLEN-1:XLEN];
               end else begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  finish_load  = !is_store_q;
               end
            end
         end
         ACC1: begin
            if (!dc_read_q && !dc_write_q) begin
               dc_read_d  = !is_store_q;
               dc_write_d = is_store_q;
            end else if (bus.dcache_resp) begin
               dc_read_d    = 1'b0;
               dc_write_d   = 1'b0;
               if (!is_store_q) buf_hi_d = bus.dcache_rdata;
               state_d      = DONE;
               resp_valid_d = 1'b1;
               finish_load  = !is_store_q;
            end
         end
         DONE: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
            req_ready_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // extraction uses the buffers as they will be after this cycle's capture
      shifted = {buf_hi_d, buf_lo_d} >> {off_q, 3'b000};
      nbits   = 7'd8 << f3_q[1:0];
      for (int i = 0; i < XLEN; i++)
         ext[i] = (i < int'(nbits)) ? shifted[i] : (!f3_q[2] && shifted[nbits-7'd1]);
      if (finish_load) resp_rdata_d = ext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         f3_q         <= '0;
         off_q        <= '0;
         split_q      <= 1'b0;
         addr_q       <= '0;
         mask_q       <= '0;
         data_q       <= '0;
         buf_lo_q     <= '0;
         buf_hi_q     <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         dc_read_q    <= 1'b0;
         dc_write_q   <= 1'b0;
         dc_addr_q    <= '0;
         dc_wdata_q   <= '0;
         dc_mbe_q     <= '0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         split_q      <= split_d;
         addr_q       <= addr_d;
         mask_q       <= mask_d;
         data_q       <= data_d;
         buf_lo_q     <= buf_lo_d;
         buf_hi_q     <= buf_hi_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         dc_read_q    <= dc_read_d;
         dc_write_q   <= dc_write_d;
         dc_addr_q    <= dc_addr_d;
         dc_wdata_q   <= dc_wdata_d;
         dc_mbe_q     <= dc_mbe_d;
      end
   end

   assign bus.req_ready      = req_ready_q;
   assign bus.resp_valid     = resp_valid_q;
   assign bus.resp_err       = resp_err_q;
   assign bus.resp_rdata     = resp_rdata_q;
   assign bus.dcache_read    = dc_read_q;
   assign bus.dcache_write   = dc_write_q;
   assign bus.dcache_address = dc_addr_q;
   assign bus.dcache_wdata   = dc_wdata_q;
   assign bus.dcache_mbe     = dc_mbe_q;
endmodule

// File: tb/tb_lsu_split.sv
`timescale 1ns/1ps
// tb_lsu_split: directed bench for lsu_split with one XLEN=32 and one XLEN=64 instance.
module tb_lsu_split;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_split_if #(.XLEN(32), .ADDR_W(32)) b32 ();
   lsu_split_if #(.XLEN(64), .ADDR_W(32)) b64 ();

   lsu_split #(.XLEN(32), .ADDR_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));
   lsu_split #(.XLEN(64), .ADDR_W(32)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

   int total = 0;
   int bad   = 0;

   logic [31:0] a;
   logic [3:0]  m;
   logic [31:0] wd;
   logic [31:0] a64;
   logic [7:0]  m64;
   logic [63:0] wd64;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req32(input logic w, input logic [2:0] f3, input logic [31:0] ad,
                        input logic [31:0] d);
      int n = 0;
      while (!b32.req_ready && n < 20) begin tick(); n++; end
      check("req32_ready_timeout", 64'(n < 20), 64'd1);
      b32.req_valid = 1'b1; b32.req_write = w; b32.req_funct3 = f3;
      b32.req_addr = ad; b32.req_wdata = d;
      tick();
      b32.req_valid = 1'b0;
   endtask

   task automatic req64(input logic w, input logic [2:0] f3, input logic [31:0] ad,
                        input logic [63:0] d);
      int n = 0;
      while (!b64.req_ready && n < 20) begin tick(); n++; end
      check("req64_ready_timeout", 64'(n < 20), 64'd1);
      b64.req_valid = 1'b1; b64.req_write = w; b64.req_funct3 = f3;
      b64.req_addr = ad; b64.req_wdata = d;
      tick();
      b64.req_valid = 1'b0;
   endtask

   // waits for the strobe, holds off `waits` cycles, then answers with one dcache_resp
   task automatic acc32(input logic [31:0] rd, input int waits,
                        output logic [31:0] ao, output logic [3:0] mo, output logic [31:0] wo);
      int n = 0;
      while (!(b32.dcache_read || b32.dcache_write) && n < 20) begin tick(); n++; end
      check("acc32_strobe_timeout", 64'(n < 20), 64'd1);
      ao = b32.dcache_address; mo = b32.dcache_mbe; wo = b32.dcache_wdata;
      repeat (waits) tick();
      check("acc32_strobe_held", 64'(b32.dcache_read || b32.dcache_write), 64'd1);
      b32.dcache_rdata = rd; b32.dcache_resp = 1'b1;
      tick();
      b32.dcache_resp = 1'b0;
   endtask

   task automatic acc64(input logic [63:0] rd,
                        output logic [31:0] ao, output logic [7:0] mo, output logic [63:0] wo);
      int n = 0;
      while (!(b64.dcache_read || b64.dcache_write) && n < 20) begin tick(); n++; end
      check("acc64_strobe_timeout", 64'(n < 20), 64'd1);
      ao = b64.dcache_address; mo = b64.dcache_mbe; wo = b64.dcache_wdata;
      b64.dcache_rdata = rd; b64.dcache_resp = 1'b1;
      tick();
      b64.dcache_resp = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      b32.req_valid = 1'b0; b32.req_write = 1'b0; b32.req_funct3 = 3'b000;
      b32.req_addr = '0; b32.req_wdata = '0; b32.dcache_rdata = '0; b32.dcache_resp = 1'b0;
      b64.req_valid = 1'b0; b64.req_write = 1'b0; b64.req_funct3 = 3'b000;
      b64.req_addr = '0; b64.req_wdata = '0; b64.dcache_rdata = '0; b64.dcache_resp = 1'b0;
      repeat (2) tick();

      check("rst_ready",  64'(b32.req_ready), 64'd1);
      check("rst_valid",  64'(b32.resp_valid), 64'd0);
      check("rst_err",    64'(b32.resp_err), 64'd0);
      check("rst_rdata",  64'(b32.resp_rdata), 64'd0);
      check("rst_read",   64'(b32.dcache_read), 64'd0);
      check("rst_write",  64'(b32.dcache_write), 64'd0);
      check("rst_addr",   64'(b32.dcache_address), 64'd0);
      check("rst_mbe",    64'(b32.dcache_mbe), 64'd0);
      check("rst_wdata",  64'(b32.dcache_wdata), 64'd0);
      rst = 1'b1;
      tick();

      // sw aligned, two wait cycles
      req32(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
      check("sw_ready_low", 64'(b32.req_ready), 64'd0);
      check("sw_is_write", 64'(b32.dcache_write), 64'd1);
      check("sw_no_read", 64'(b32.dcache_read), 64'd0);
      acc32(32'h0, 2, a, m, wd);
      check("sw_addr",  64'(a), 64'h1000);
      check("sw_mbe",   64'(m), 64'hF);
      check("sw_wdata", 64'(wd), 64'hDEAD_BEEF);
      check("sw_resp_valid", 64'(b32.resp_valid), 64'd1);
      check("sw_resp_err", 64'(b32.resp_err), 64'd0);
      check("sw_resp_rdata", 64'(b32.resp_rdata), 64'd0);
      check("sw_strobe_off", 64'(b32.dcache_write), 64'd0);
      tick();
      check("sw_valid_pulse", 64'(b32.resp_valid), 64'd0);
      check("sw_ready_back", 64'(b32.req_ready), 64'd1);

      // sh crossing a word boundary
      req32(1'b1, 3'b001, 32'h0000_1003, 32'h0000_ABCD);
      acc32(32'h0, 0, a, m, wd);
      check("sh_acc0_addr",  64'(a), 64'h1000);
      check("sh_acc0_mbe",   64'(m), 64'h8);
      check("sh_acc0_wdata", 64'(wd), 64'hCD00_0000);
      check("sh_gap_strobe", 64'(b32.dcache_write || b32.dcache_read), 64'd0);
      check("sh_gap_novalid", 64'(b32.resp_valid), 64'd0);
      tick();
      check("sh_acc1_strobe", 64'(b32.dcache_write), 64'd1);
      acc32(32'h0, 0, a, m, wd);
      check("sh_acc1_addr",  64'(a), 64'h1004);
      check("sh_acc1_mbe",   64'(m), 64'h1);
      check("sh_acc1_wdata", 64'(wd), 64'h0000_00AB);
      check("sh_resp_valid", 64'(b32.resp_valid), 64'd1);
      tick();

      // lb / lbu / lh sign and zero extension
      req32(1'b0, 3'b000, 32'h0000_2002, 32'h0);
      check("lb_is_read", 64'(b32.dcache_read), 64'd1);
      acc32(32'h12F4_5678, 0, a, m, wd);
      check("lb_mbe", 64'(m), 64'h4);
      check("lb_resp_valid", 64'(b32.resp_valid), 64'd1);
      check("lb_rdata", 64'(b32.resp_rdata), 64'hFFFF_FFF4);
      tick();
      req32(1'b0, 3'b100, 32'h0000_2002, 32'h0);
      acc32(32'h12F4_5678, 0, a, m, wd);
      check("lbu_rdata", 64'(b32.resp_rdata), 64'h0000_00F4);
      tick();
      req32(1'b0, 3'b001, 32'h0000_2002, 32'h0);
      acc32(32'h8001_0000, 0, a, m, wd);
      check("lh_rdata", 64'(b32.resp_rdata), 64'hFFFF_8001);
      tick();

      // lw split, reassembled
      req32(1'b0, 3'b010, 32'h0000_2003, 32'h0);
      acc32(32'hAABB_CCDD, 0, a, m, wd);
      tick();
      acc32(32'h1122_3344, 0, a, m, wd);
      check("lw_split_addr1", 64'(a), 64'h2004);
      check("lw_split_valid", 64'(b32.resp_valid), 64'd1);
      check("lw_split_rdata", 64'(b32.resp_rdata), 64'h2233_44AA);
      tick();

      // lw split with address wrap
      req32(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
      acc32(32'h4433_2211, 0, a, m, wd);
      check("wrap_addr0", 64'(a), 64'hFFFF_FFFC);
      tick();
      acc32(32'h8877_6655, 0, a, m, wd);
      check("wrap_addr1", 64'(a), 64'h0);
      check("wrap_rdata", 64'(b32.resp_rdata), 64'h6655_4433);
      tick();

      // illegal ld on XLEN=32 and illegal store funct3
      req32(1'b0, 3'b011, 32'h0000_2000, 32'h0);
      check("ld32_no_read", 64'(b32.dcache_read), 64'd0);
      check("ld32_no_write", 64'(b32.dcache_write), 64'd0);
      check("ld32_valid", 64'(b32.resp_valid), 64'd1);
      check("ld32_err", 64'(b32.resp_err), 64'd1);
      check("ld32_rdata", 64'(b32.resp_rdata), 64'd0);
      tick();
      check("ld32_err_clear", 64'(b32.resp_err), 64'd0);
      check("ld32_valid_clear", 64'(b32.resp_valid), 64'd0);
      req32(1'b1, 3'b100, 32'h0000_2000, 32'h1234_5678);
      check("st100_err", 64'(b32.resp_err), 64'd1);
      check("st100_no_write", 64'(b32.dcache_write), 64'd0);
      tick();

      // XLEN=64 lwu split
      req64(1'b0, 3'b110, 32'h0000_0006, 64'h0);
      acc64(64'h8877_6655_4433_2211, a64, m64, wd64);
      check("lwu64_addr0", 64'(a64), 64'h0);
      check("lwu64_mbe0", 64'(m64), 64'hC0);
      tick();
      acc64(64'h0000_0000_0000_00AA, a64, m64, wd64);
      check("lwu64_addr1", 64'(a64), 64'h8);
      check("lwu64_mbe1", 64'(m64), 64'h03);
      check("lwu64_valid", 64'(b64.resp_valid), 64'd1);
      check("lwu64_rdata", b64.resp_rdata, 64'h0000_0000_00AA_8877);
      tick();

      // reset in the middle of ACC0
      req32(1'b0, 3'b010, 32'h0000_3000, 32'h0);
      check("rstmid_read_before", 64'(b32.dcache_read), 64'd1);
      #1 rst = 1'b0;
      #1;
      check("rstmid_read_off", 64'(b32.dcache_read), 64'd0);
      check("rstmid_ready", 64'(b32.req_ready), 64'd1);
      tick();
      rst = 1'b1;
      b32.dcache_rdata = 32'hFFFF_FFFF; b32.dcache_resp = 1'b1;
      tick();
      b32.dcache_resp = 1'b0;
      check("rstmid_stale_novalid", 64'(b32.resp_valid), 64'd0);
      check("rstmid_stale_noread", 64'(b32.dcache_read), 64'd0);
      tick();
      check("rstmid_novalid2", 64'(b32.resp_valid), 64'd0);
      check("rstmid_ready2", 64'(b32.req_ready), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
